equiv_checker: RTL and testbench

Synthesizable stimulus-and-response engine for gate-level equivalence runs on small combinational functions. It drives an exhaustive N_IN-bit input sweep into three parallel implementations of the same function. After a settle window it samples their outputs and flags any vector where they disagree. It accumulates an error count, captures the first failing vector, and reports done/pass to the surrounding harness.

---
 rtl/equiv_chk_pkg.sv | 18 +
 rtl/equiv_checker_settle_timer.sv | 30 +++
 rtl/equiv_checker.sv | 109 ++++++++++
 tb/tb_equiv_checker.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/equiv_chk_pkg.sv
// Shared types and helpers for the equivalence-checker stimulus/response engine.
package equiv_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_IMPL = 3;

  // True when every implementation produced the same response bit.
  function automatic logic all_equal(input logic [2:0] resp);
    return (resp == 3'b000) || (resp == 3'b111);
  endfunction

endpackage

// File: rtl/equiv_checker_settle_timer.sv
// Loadable down-counter; tc flags the last cycle of a settle window of SETTLE cycles.
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [W-1:0] INIT = W'(SETTLE - 1);

  logic [W-1:0] count;

  // Count register: reload outside the window, count down inside it, park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= INIT;
    end else if (en && (count != {W{1'b0}})) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign tc = (count == {W{1'b0}});

endmodule

// File: rtl/equiv_checker.sv
// Exhaustive N_IN-bit sweep into three implementations, counting vectors whose responses disagree.
module equiv_checker
  import equiv_chk_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_IMPL-1:0] dut_out,
  output logic [N_IN-1:0]     stim,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_count,
  output logic                first_fail_valid,
  output logic [N_IN-1:0]     first_fail_vec,
  output logic [NUM_IMPL-1:0] first_fail_resp
);

  localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};

  state_t        state;
  logic          tmr_load;
  logic          tmr_en;
  logic          tmr_tc;
  logic          mismatch;
  logic          last_vec;
  logic [N_IN:0] err_next;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (tmr_en),
    .tc   (tmr_tc)
  );

  // Timer is primed in every non-APPLY cycle so each vector starts a fresh window.
  always_comb begin
    tmr_load = (state != APPLY);
    tmr_en   = (state == APPLY);
    mismatch = !all_equal(dut_out);
    last_vec = (stim == STIM_LAST);
    if (mismatch) begin
      err_next = err_count + {{N_IN{1'b0}}, 1'b1};
    end else begin
      err_next = err_count;
    end
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      stim             <= {N_IN{1'b0}};
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= {(N_IN+1){1'b0}};
      first_fail_valid <= 1'b0;
      first_fail_vec   <= {N_IN{1'b0}};
      first_fail_resp  <= {NUM_IMPL{1'b0}};
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= APPLY;
            stim             <= {N_IN{1'b0}};
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= {(N_IN+1){1'b0}};
            first_fail_valid <= 1'b0;
            first_fail_vec   <= {N_IN{1'b0}};
            first_fail_resp  <= {NUM_IMPL{1'b0}};
          end
        end
        APPLY: begin
          if (tmr_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= stim;
            first_fail_resp  <= dut_out;
          end
          if (last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == {(N_IN+1){1'b0}});
          end else begin
            state <= APPLY;
            stim  <= stim + {{(N_IN-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_checker.sv
// Directed bench: models three implementations of f(stim)=stim[0] with selectable faults.
module tb_equiv_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] dut_out;
  logic [3:0] stim;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic       first_fail_valid;
  logic [3:0] first_fail_vec;
  logic [2:0] first_fail_resp;

  int         mode;
  logic [3:0] prev_stim;
  logic       f;
  int         n_assert = 0;
  int         n_fail   = 0;

  equiv_checker #(.N_IN(4), .SETTLE(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .dut_out          (dut_out),
    .stim             (stim),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec),
    .first_fail_resp  (first_fail_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prev_stim <= stim;

  // mode 0: healthy, 1: impl1 wrong at 0101, 2: impl2 always wrong, 3: glitch in first cycle of vector 3
  always_comb begin
    f = stim[0];
    dut_out = {f, f, f};
    case (mode)
      1: if (stim == 4'b0101) dut_out[1] = ~f;
      2: dut_out[2] = ~f;
      3: if (stim == 4'd3 && prev_stim != 4'd3) dut_out = 3'b010;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".stim"}, 32'(stim), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".pass"}, 32'(pass), 32'd0);
    chk({tag, ".err"},  32'(err_count), 32'd0);
    chk({tag, ".ffv"},  32'(first_fail_valid), 32'd0);
    chk({tag, ".ffvec"}, 32'(first_fail_vec), 32'd0);
    chk({tag, ".ffresp"}, 32'(first_fail_resp), 32'd0);
  endtask

  // Start accepted at edge k; done must appear exactly 48 edges later (SETTLE+1 cycles x 16 vectors).
  task automatic sweep(input string name, input int mid_vec, input logic [4:0] exp_err,
                       input logic exp_pass, input logic exp_ffv, input logic [3:0] exp_vec,
                       input logic [2:0] exp_resp);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({name, ".start_busy"}, 32'(busy), 32'd1);
    chk({name, ".start_stim"}, 32'(stim), 32'd0);
    chk({name, ".start_done"}, 32'(done), 32'd0);
    chk({name, ".start_pass"}, 32'(pass), 32'd0);
    chk({name, ".start_err"},  32'(err_count), 32'd0);
    chk({name, ".start_ffv"},  32'(first_fail_valid), 32'd0);
    for (int e = 1; e <= 48; e++) begin
      start = (mid_vec >= 0 && e == 3 * mid_vec + 1) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (e % 3 == 0 && e < 48) chk({name, ".stim_seq"}, 32'(stim), 32'(e / 3));
      if (e == 47) begin
        chk({name, ".done_early"}, 32'(done), 32'd0);
        chk({name, ".busy_late"}, 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    chk({name, ".done"},   32'(done), 32'd1);
    chk({name, ".busy"},   32'(busy), 32'd0);
    chk({name, ".pass"},   32'(pass), 32'(exp_pass));
    chk({name, ".err"},    32'(err_count), 32'(exp_err));
    chk({name, ".ffv"},    32'(first_fail_valid), 32'(exp_ffv));
    chk({name, ".ffvec"},  32'(first_fail_vec), 32'(exp_vec));
    chk({name, ".ffresp"}, 32'(first_fail_resp), 32'(exp_resp));
    chk({name, ".stim_end"}, 32'(stim), 32'hF);
  endtask

  initial begin
    mode  = 0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");

    mode = 0;
    sweep("clean", -1, 5'd0, 1'b1, 1'b0, 4'd0, 3'b000);
    mode = 1;
    sweep("single", -1, 5'd1, 1'b0, 1'b1, 4'b0101, 3'b101);
    mode = 2;
    sweep("all_bad", -1, 5'b10000, 1'b0, 1'b1, 4'd0, 3'b100);
    mode = 3;
    sweep("glitch", -1, 5'd0, 1'b1, 1'b0, 4'd0, 3'b000);
    mode = 2;
    sweep("mid_start", 6, 5'b10000, 1'b0, 1'b1, 4'd0, 3'b100);
    mode = 0;
    sweep("restart", -1, 5'd0, 1'b1, 1'b0, 4'd0, 3'b000);

    // Reset during vector 7 with start also asserted.
    mode = 2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (21) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst.stim", 32'(stim), 32'd7);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk_idle("mid_rst");
    @(posedge clk);
    @(negedge clk);
    chk_idle("post_rst_idle");
    mode = 0;
    sweep("after_rst", -1, 5'd0, 1'b1, 1'b0, 4'd0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
